// File: rtl/alu_pkg.sv
// Shared ALU result types: opcode encodings, packed flag word and queue entry layout.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    typedef struct packed {
        alu_op_e    op;
        logic [31:0] y;
        alu_flags_t flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_res_fifo.sv
// Storage and pointer logic for the ALU result queue: registered-occupancy FIFO, no bypass.
module alu_res_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 39
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_wr_valid,
    output logic                         o_wr_ready,
    input  logic [W-1:0]                 i_wr_data,
    output logic                         o_rd_valid,
    input  logic                         i_rd_ready,
    output logic [W-1:0]                 o_rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Handshake readiness depends only on registered occupancy, never on i_rd_ready.
    assign o_wr_ready = (r_count != CNT_W'(DEPTH));
    assign o_rd_valid = (r_count != '0);
    assign w_push     = i_wr_valid && o_wr_ready;
    assign w_pop      = o_rd_valid && i_rd_ready;
    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_queue.sv
// ALU result queue top: entry packing around alu_res_fifo plus optional sticky carry/overflow.
// Define ALU_RESULT_QUEUE_STICKY_EN to add sticky_c/sticky_v/sticky_clr.
module alu_result_queue
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OP_W  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [OP_W-1:0]             in_op,
    input  logic [31:0]                 in_y,
    input  logic [3:0]                  in_flags,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OP_W-1:0]             out_op,
    output logic [31:0]                 out_y,
    output logic [3:0]                  out_flags,
`ifdef ALU_RESULT_QUEUE_STICKY_EN
    output logic                        sticky_c,
    output logic                        sticky_v,
    input  logic                        sticky_clr,
`endif
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int unsigned ENT_W = OP_W + 32 + 4;

    logic [ENT_W-1:0] w_wr_data;
    logic [ENT_W-1:0] w_rd_data;

    assign w_wr_data = {in_op, in_y, in_flags};
    assign {out_op, out_y, out_flags} = w_rd_data;

    alu_res_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr_valid (in_valid),
        .o_wr_ready (in_ready),
        .i_wr_data  (w_wr_data),
        .o_rd_valid (out_valid),
        .i_rd_ready (out_ready),
        .o_rd_data  (w_rd_data),
        .o_count    (count)
    );

`ifdef ALU_RESULT_QUEUE_STICKY_EN
    alu_flags_t w_in_flags;
    logic       w_arith_push;
    logic       r_sticky_c;
    logic       r_sticky_v;

    assign w_in_flags   = alu_flags_t'(in_flags);
    assign w_arith_push = in_valid && in_ready &&
                          ((in_op == OP_W'(OP_ADD)) || (in_op == OP_W'(OP_SUB)));

    // A qualifying set on the same edge as sticky_clr leaves the bit at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky_c <= 1'b0;
            r_sticky_v <= 1'b0;
        end else begin
            r_sticky_c <= (r_sticky_c && !sticky_clr) || (w_arith_push && w_in_flags.c);
            r_sticky_v <= (r_sticky_v && !sticky_clr) || (w_arith_push && w_in_flags.v);
        end
    end

    assign sticky_c = r_sticky_c;
    assign sticky_v = r_sticky_v;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed self-checking bench for alu_result_queue (DEPTH=4, OP_W=3).
module tb_alu_result_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_y;
    logic [3:0]  in_flags;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [31:0] out_y;
    logic [3:0]  out_flags;
    logic [2:0]  count;
`ifdef ALU_RESULT_QUEUE_STICKY_EN
    logic        sticky_c;
    logic        sticky_v;
    logic        sticky_clr;
`endif

    int total;
    int bad;

    alu_result_queue #(
        .DEPTH (4),
        .OP_W  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_y       (in_y),
        .in_flags   (in_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_y      (out_y),
        .out_flags  (out_flags),
`ifdef ALU_RESULT_QUEUE_STICKY_EN
        .sticky_c   (sticky_c),
        .sticky_v   (sticky_v),
        .sticky_clr (sticky_clr),
`endif
        .count      (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_op = 3'b000; in_y = 32'h0000_0005; in_flags = 4'b0000;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_no_bypass: got %b want 0", out_valid); end
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
        total++; if (out_y !== 32'h5) begin bad++; $display("FAIL single_out_y: got %h want 5", out_y); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count: got %0d want 1", count); end
        total++; if (out_op !== 3'b000) begin bad++; $display("FAIL single_out_op: got %b want 000", out_op); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL single_pop_count: got %0d want 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_op = 3'(i); in_y = 32'(i); in_flags = 4'(i + 8);
            step();
        end
        in_valid = 1'b0;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count: got %0d want 4", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++; if (out_y !== 32'(i)) begin bad++; $display("FAIL drain_y%0d: got %0d want %0d", i, out_y, i); end
            total++; if (out_op !== 3'(i)) begin bad++; $display("FAIL drain_op%0d: got %0d want %0d", i, out_op, i); end
            total++; if (out_flags !== 4'(i + 8)) begin bad++; $display("FAIL drain_flags%0d: got %0d want %0d", i, out_flags, i + 8); end
            step();
            if (i == 1) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_in_ready: got %b want 1", in_ready); end
            end
        end
        out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL drain_count: got %0d want 0", count); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_op = 3'b011; in_y = 32'(10 + i); in_flags = 4'b0000;
            step();
        end
        in_y = 32'd14; out_ready = 1'b1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        step();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL full_pop_count: got %0d want 3", count); end
        total++; if (out_y !== 32'd11) begin bad++; $display("FAIL full_pop_head: got %0d want 11", out_y); end
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_refill_count: got %0d want 4", count); end
        out_ready = 1'b1;
        for (int i = 11; i <= 14; i++) begin
            total++; if (out_y !== 32'(i)) begin bad++; $display("FAIL full_drain_y: got %0d want %0d", out_y, i); end
            step();
        end
        out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL full_drain_count: got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_op = 3'b100; in_y = 32'd100; in_flags = 4'b0001;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_y = 32'(101 + i);
            total++; if (out_y !== 32'(100 + i)) begin bad++; $display("FAIL b2b_y%0d: got %0d want %0d", i, out_y, 100 + i); end
            total++; if (count !== 3'd1) begin bad++; $display("FAIL b2b_count%0d: got %0d want 1", i, count); end
            step();
        end
        in_valid = 1'b0;
        total++; if (out_y !== 32'd110) begin bad++; $display("FAIL b2b_last_y: got %0d want 110", out_y); end
        step();
        out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL b2b_end_count: got %0d want 0", count); end
    endtask

`ifdef ALU_RESULT_QUEUE_STICKY_EN
    task automatic test_sticky();
        in_valid = 1'b1; in_op = 3'b001; in_y = 32'd7; in_flags = 4'b0111;
        step();
        total++; if ({sticky_c, sticky_v} !== 2'b11) begin bad++; $display("FAIL sticky_sub: got %b want 11", {sticky_c, sticky_v}); end
        in_op = 3'b010; in_flags = 4'b0010;
        step();
        total++; if ({sticky_c, sticky_v} !== 2'b11) begin bad++; $display("FAIL sticky_and: got %b want 11", {sticky_c, sticky_v}); end
        in_op = 3'b000; in_flags = 4'b0001; sticky_clr = 1'b1;
        step();
        in_valid = 1'b0; sticky_clr = 1'b0;
        total++; if ({sticky_c, sticky_v} !== 2'b01) begin bad++; $display("FAIL sticky_clr_win: got %b want 01", {sticky_c, sticky_v}); end
    endtask
`endif

    task automatic test_mid_reset();
        if (count == 3'd0) begin
            for (int i = 0; i < 3; i++) begin
                in_valid = 1'b1; in_op = 3'b101; in_y = 32'(200 + i); in_flags = 4'b1000;
                step();
            end
        end
        in_valid = 1'b0;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL mreset_pre_count: got %0d want 3", count); end
        in_valid = 1'b1; out_ready = 1'b1;
        rst = 1'b1;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL mreset_count: got %0d want 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mreset_out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mreset_in_ready: got %b want 1", in_ready); end
`ifdef ALU_RESULT_QUEUE_STICKY_EN
        total++; if ({sticky_c, sticky_v} !== 2'b00) begin bad++; $display("FAIL mreset_sticky: got %b want 00", {sticky_c, sticky_v}); end
`endif
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL mreset_no_push: got %0d want 0", count); end
        step();
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_y = '0; in_flags = '0; out_ready = 1'b0;
`ifdef ALU_RESULT_QUEUE_STICKY_EN
        sticky_clr = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_single();
        test_fill_drain();
        test_full_push_pop();
        test_back_to_back();
`ifdef ALU_RESULT_QUEUE_STICKY_EN
        test_sticky();
`endif
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_queue.md
ALU_RESULT_QUEUE -- requirements
Module: alu_result_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered ALU result entries (power of two, 2..16).
REQ-002 Parameter OP_W, default 3, width of the op tag carried with each result.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream ALU result present this cycle.
REQ-006 in_ready  output  1  queue can accept an entry this cycle.
REQ-007 in_op  input  OP_W  opcode that produced the result (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT).
REQ-008 in_y  input  32  ALU result word.
REQ-009 in_flags  input  4  ALU flags packed {z,n,c,v}.
REQ-010 out_valid  output  1  head entry available.
REQ-011 out_ready  input  1  downstream accepts the head entry.
REQ-012 out_op / out_y / out_flags  output  OP_W / 32 / 4  head entry fields.
REQ-013 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-014 sticky_c, sticky_v  output  1 each  accumulated carry/overflow status (present only when configured, REQ-030).
REQ-015 sticky_clr  input  1  clear request for sticky status (present only when configured).

Function
REQ-016 Push occurs on a clock edge when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-017 in_ready = (count != DEPTH), driven from registered state only, never from out_ready.
REQ-018 out_valid = (count != 0); out_* fields show the head entry combinationally from storage.
REQ-019 Latency: an entry pushed at edge k is visible on out_* after edge k; no same-cycle bypass when empty.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH: both occur, count unchanged, order preserved.
REQ-021 Full (count == DEPTH): in_ready low even if out_ready high; a pop that cycle frees space for the next cycle.
REQ-022 Empty: out_valid low; out_* hold the last-read storage value and are don't-care.
REQ-023 Read and write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-024 Entries are stored and delivered unmodified, strictly FIFO.
REQ-025 out_* fields and out_valid remain stable while out_valid && !out_ready.

Reset
REQ-026 rst asserted at any time, including mid-transfer, empties the queue on the same cycle: pointers 0, count 0, out_valid 0, in_ready 1.
REQ-027 sticky_c and sticky_v reset to 0; storage contents are not reset.
REQ-028 No push or pop takes effect on an edge where rst is high.

Configuration
REQ-029 Macro ALU_RESULT_QUEUE_STICKY_EN enables the sticky status feature.
REQ-030 With the macro defined: on each push with in_op ADD or SUB, sticky_c |= in_flags[1] and sticky_v |= in_flags[0]; sticky_clr zeroes both, but a same-cycle qualifying set wins (the bit ends at 1).
REQ-031 Without the macro: sticky_c, sticky_v and sticky_clr ports are absent and no sticky logic is generated.

Structure
REQ-032 Shared package alu_pkg holds the op enum (ADD..SLT encodings), the alu_flags_t packed struct {z,n,c,v} and the result-entry struct {op, y, flags}.
REQ-033 Storage and pointer logic live in one sub-module alu_res_fifo; sticky logic and port mapping live in alu_result_queue.

Verification
REQ-034 Reset, then push ADD y=0x0000_0005 flags=0000 -> out_valid high one cycle later, out_y=0x5, count=1.
REQ-035 Push 4 entries y=1,2,3,4 with out_ready=0 -> count=4, in_ready=0; then out_ready=1 -> outputs 1,2,3,4 in order, in_ready high after first pop.
REQ-036 Full, push and pop in the same cycle -> only pop occurs, count 4->3; next cycle push accepted, count=4.
REQ-037 Steady push+pop each cycle for 10 cycles with DEPTH=4 -> count stays 1, pointers wrap twice, no entry lost or duplicated.
REQ-038 STICKY_EN: push SUB flags {0,1,1,1} -> sticky_c=1, sticky_v=1; push AND flags c=1 -> no change; sticky_clr with concurrent ADD v=1 -> sticky_v=1, sticky_c=0.
REQ-039 Assert rst with count=3 and out_valid high -> same cycle count=0, out_valid=0, in_ready=1, sticky bits 0.
